// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy fan-out/fan-in node.
package hier_node_pkg;

  typedef enum logic [0:0] {DISP_RR, DISP_LOWEST} dispatch_mode_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_ISSUE} req_state_e;

  localparam int CNT_W = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hier_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at N.
module hier_rr_arb #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from the farthest position back to ptr so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hier_node_dispatch.sv
// Hierarchy node: dispatches parent requests to NUM_CHILD children with per-child
// outstanding limits and returns child responses to the parent tagged with the child index.
module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILD     = 5,
  parameter int DATA_W        = 32,
  parameter int MAX_OUTST     = 4,
  parameter int DISPATCH_MODE = 0,
  localparam int CW           = clog2_min1(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up_req_valid,
  output logic                        up_req_ready,
  input  logic [DATA_W-1:0]           up_req_data,
  output logic [NUM_CHILD-1:0]        dn_req_valid,
  input  logic [NUM_CHILD-1:0]        dn_req_ready,
  output logic [DATA_W-1:0]           dn_req_data,
  input  logic [NUM_CHILD-1:0]        dn_rsp_valid,
  output logic [NUM_CHILD-1:0]        dn_rsp_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] dn_rsp_data,
  output logic                        up_rsp_valid,
  input  logic                        up_rsp_ready,
  output logic [DATA_W-1:0]           up_rsp_data,
  output logic [CW-1:0]               up_rsp_child,
  output logic [CW+3:0]               outst_total,
  output logic                        err_underflow,
  output req_state_e                  req_state
);

  // Handshakes: a transfer happens on a clk edge where valid and ready are both high.
  // Valid is never withdrawn and its payload never changes until that transfer.

  localparam logic MODE_RR = (DISPATCH_MODE == int'(DISP_RR));

  req_state_e           state, state_nxt;
  logic [DATA_W-1:0]    req_data;
  logic [CW-1:0]        sel, rr_req_ptr, rr_rsp_ptr, sel_ptr, sel_idx, rsp_idx;
  logic [NUM_CHILD-1:0] elig, sel_grant, rsp_grant, inc, dec;
  logic [CNT_W-1:0]     cnt [NUM_CHILD];
  logic                 sel_any, issue_fire, up_accept, rsp_accept, rsp_fire;
  logic [CW+3:0]        cnt_sum;

  function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
    return (i == CW'(NUM_CHILD - 1)) ? '0 : i + CW'(1);
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CHILD; i++) elig[i] = (cnt[i] < CNT_W'(MAX_OUTST));
  end

  // Lowest-index mode is the same scan anchored at child 0.
  assign sel_ptr = MODE_RR ? rr_req_ptr : '0;

  hier_rr_arb #(.N(NUM_CHILD), .IW(CW)) u_sel_arb (
    .req   (elig),
    .ptr   (sel_ptr),
    .grant (sel_grant),
    .idx   (sel_idx)
  );

  assign sel_any = |sel_grant;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (up_req_valid) state_nxt = ST_SELECT;
      ST_SELECT: if (sel_any) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (issue_fire) state_nxt = up_req_valid ? ST_SELECT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dn_req_valid = '0;
    issue_fire   = 1'b0;
    up_req_ready = 1'b0;
    if (state == ST_ISSUE) begin
      dn_req_valid[sel] = 1'b1;
      issue_fire        = dn_req_ready[sel];
    end
    // In ISSUE the parent slot frees only in the child handshake cycle.
    if (!rst) up_req_ready = (state == ST_IDLE) || issue_fire;
  end

  assign up_accept   = up_req_valid & up_req_ready;
  assign dn_req_data = req_data;
  assign req_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_data   <= '0;
      sel        <= '0;
      rr_req_ptr <= '0;
    end else begin
      if (up_accept) req_data <= up_req_data;
      if (state == ST_SELECT && sel_any) sel <= sel_idx;
      if (issue_fire && MODE_RR) rr_req_ptr <= next_idx(sel);
    end
  end

  hier_rr_arb #(.N(NUM_CHILD), .IW(CW)) u_rsp_arb (
    .req   (dn_rsp_valid),
    .ptr   (rr_rsp_ptr),
    .grant (rsp_grant),
    .idx   (rsp_idx)
  );

  assign rsp_accept   = !rst && (!up_rsp_valid || up_rsp_ready);
  assign rsp_fire     = (|rsp_grant) && rsp_accept;
  assign dn_rsp_ready = rsp_accept ? rsp_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_rsp_valid <= 1'b0;
      up_rsp_data  <= '0;
      up_rsp_child <= '0;
      rr_rsp_ptr   <= '0;
    end else if (rsp_fire) begin
      up_rsp_valid <= 1'b1;
      up_rsp_data  <= dn_rsp_data[int'(rsp_idx)*DATA_W +: DATA_W];
      up_rsp_child <= rsp_idx;
      rr_rsp_ptr   <= next_idx(rsp_idx);
    end else if (up_rsp_ready) begin
      up_rsp_valid <= 1'b0;
    end
  end

  assign inc = dn_req_valid & dn_req_ready;
  assign dec = dn_rsp_valid & dn_rsp_ready;

  always_comb begin
    cnt_sum = '0;
    for (int i = 0; i < NUM_CHILD; i++) cnt_sum = cnt_sum + (CW+4)'(cnt[i]);
  end

  // A child at MAX_OUTST is never selected, so increments cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHILD; i++) cnt[i] <= '0;
      err_underflow <= 1'b0;
      outst_total   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i]) begin
          if (cnt[i] == '0) err_underflow <= 1'b1;
          else              cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      outst_total <= cnt_sum;
    end
  end

endmodule
